// File: rtl/sram_sysace_writer_if.sv
// Bus bundle for sram_sysace_writer: CF sector-write command channel, SRAM read port and the
// halfword stream toward the SystemACE sector-write FIFO.
interface sram_sysace_writer_if;
  logic [27:0] cmd_lba;
  logic [7:0]  cmd_nsectors;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [20:0] data_r_address;
  logic        data_r_re;
  logic        data_r_full;
  logic [31:0] data_r;
  logic        data_r_valid;
  logic [15:0] sysace_write_data;
  logic        sysace_write_valid;
  logic        sysace_write_ready;

  modport master (
    output cmd_lba, cmd_nsectors, cmd_valid,
    input  cmd_ready,
    output data_r_address, data_r_re,
    input  data_r_full, data_r, data_r_valid,
    output sysace_write_data, sysace_write_valid,
    input  sysace_write_ready
  );

  modport slave (
    input  cmd_lba, cmd_nsectors, cmd_valid,
    output cmd_ready,
    input  data_r_address, data_r_re,
    output data_r_full, data_r, data_r_valid,
    input  sysace_write_data, sysace_write_valid,
    output sysace_write_ready
  );
endinterface

// File: rtl/sram_sysace_writer.sv
// Streams a frame of 24-bit SRAM pixels to SystemACE as byte-swapped halfwords (2 pixels -> 3
// halfwords) and issues one 256-sector write command per 2**(RowBits+8) halfwords.
module sram_sysace_writer #(
  parameter logic [27:0] LBA_BASE   = 28'h0,
  parameter logic [27:0] LBA_STRIDE = 28'd256,
  parameter int unsigned RowBits    = 8
) (
  input  logic                 CLK80,
  input  logic                 RST,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  sram_sysace_writer_if.master bus
);

  // One command covers a third of the frame, so the halfword counter spans that exactly.
  localparam int unsigned HwCntW = RowBits + 8;

  typedef enum logic [3:0] {
    StIdle, StRdA, StWaitA, StRdB, StWaitB, StOut0, StOut1, StOut2, StFin
  } state_e;

  state_e              state_q, state_d;
  logic [RowBits-1:0]  row_q, row_d;
  logic [8:0]          col_q, col_d;
  logic [23:0]         pix_a_q, pix_a_d, pix_b_q, pix_b_d;
  logic [HwCntW-1:0]   hw_cnt_q, hw_cnt_d;
  logic [1:0]          cmd_cnt_q, cmd_cnt_d;
  logic                cmd_pending_q, cmd_pending_d;
  logic [27:0]         cmd_lba_q, cmd_lba_d;
  logic                re_q, re_d;
  logic                wvalid_q, wvalid_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic rd_accept, hw_hs, cmd_hs;
  logic [7:0] row_ext;
  logic unused_data_hi;

  assign rd_accept = re_q && !bus.data_r_full;
  assign hw_hs     = wvalid_q && bus.sysace_write_ready;
  assign cmd_hs    = cmd_pending_q && bus.cmd_ready;
  assign row_ext   = 8'(row_q);
  assign unused_data_hi = ^bus.data_r[31:24];

  function automatic logic [15:0] swap_bytes(input logic [15:0] s);
    return {s[7:0], s[15:8]};
  endfunction

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    pix_a_d       = pix_a_q;
    pix_b_d       = pix_b_q;
    hw_cnt_d      = hw_cnt_q;
    cmd_cnt_d     = cmd_cnt_q;
    cmd_pending_d = cmd_pending_q;
    wdata_d       = wdata_q;

    if (rd_accept) begin
      col_d = col_q + 9'd1;
      if (col_q == 9'h1FF) begin
        row_d = row_q + RowBits'(1);
      end
    end

    if (cmd_hs) begin
      cmd_pending_d = 1'b0;
      cmd_cnt_d     = cmd_cnt_q + 2'd1;
    end

    if (hw_hs) begin
      hw_cnt_d = hw_cnt_q + HwCntW'(1);
      if ((hw_cnt_q == '1) && (cmd_cnt_q != 2'd3)) begin
        cmd_pending_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StRdA;
          row_d         = '0;
          col_d         = '0;
          hw_cnt_d      = '0;
          cmd_cnt_d     = 2'd0;
          cmd_pending_d = 1'b1;
        end
      end
      StRdA:   if (rd_accept) state_d = StWaitA;
      StWaitA: begin
        if (bus.data_r_valid) begin
          pix_a_d = bus.data_r[23:0];
          state_d = StRdB;
        end
      end
      StRdB:   if (rd_accept) state_d = StWaitB;
      StWaitB: begin
        if (bus.data_r_valid) begin
          pix_b_d = bus.data_r[23:0];
          state_d = StOut0;
        end
      end
      StOut0:  if (hw_hs) state_d = StOut1;
      StOut1:  if (hw_hs) state_d = StOut2;
      StOut2: begin
        // The address has wrapped to zero only after the final pair was read.
        if (hw_hs) state_d = ((row_q == '0) && (col_q == '0)) ? StFin : StRdA;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    re_d     = (state_d == StRdA) || (state_d == StRdB);
    wvalid_d = ((state_d == StOut0) || (state_d == StOut1) || (state_d == StOut2)) &&
               !cmd_pending_d;
    case (state_d)
      StOut0:  wdata_d = swap_bytes(pix_a_d[23:8]);
      StOut1:  wdata_d = swap_bytes({pix_a_d[7:0], pix_b_d[23:16]});
      StOut2:  wdata_d = swap_bytes(pix_b_d[15:0]);
      default: wdata_d = wdata_q;
    endcase
    busy_d    = (state_d != StIdle) && (state_d != StFin);
    done_d    = (state_d == StFin);
    cmd_lba_d = LBA_BASE + LBA_STRIDE * 28'(cmd_cnt_d);
  end

  always_ff @(posedge CLK80) begin
    if (RST) begin
      state_q       <= StIdle;
      row_q         <= '0;
      col_q         <= '0;
      pix_a_q       <= '0;
      pix_b_q       <= '0;
      hw_cnt_q      <= '0;
      cmd_cnt_q     <= 2'd0;
      cmd_pending_q <= 1'b0;
      cmd_lba_q     <= LBA_BASE;
      re_q          <= 1'b0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_a_q       <= pix_a_d;
      pix_b_q       <= pix_b_d;
      hw_cnt_q      <= hw_cnt_d;
      cmd_cnt_q     <= cmd_cnt_d;
      cmd_pending_q <= cmd_pending_d;
      cmd_lba_q     <= cmd_lba_d;
      re_q          <= re_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign busy                   = busy_q;
  assign done                   = done_q;
  assign bus.cmd_lba            = cmd_lba_q;
  assign bus.cmd_nsectors       = 8'h00;
  assign bus.cmd_valid          = cmd_pending_q;
  assign bus.data_r_address     = {4'h0, row_ext, col_q};
  assign bus.data_r_re          = re_q;
  assign bus.sysace_write_data  = wdata_q;
  assign bus.sysace_write_valid = wvalid_q;

endmodule

// File: tb/tb_sram_sysace_writer.sv
// Bench for sram_sysace_writer on a reduced 1024-word frame (RowBits=1, 512 halfwords per command).
// Expected halfwords come from treating each pixel pair as one 48-bit value cut into three words.
module tb_sram_sysace_writer;
  localparam int unsigned RowBits = 1;
  localparam int unsigned NWords  = 512 << RowBits;
  localparam int unsigned NPairs  = NWords / 2;
  localparam int unsigned NHw     = NPairs * 3;
  localparam int unsigned HwPerCmd = NHw / 3;
  localparam logic [27:0] LbaBase   = 28'h0;
  localparam logic [27:0] LbaStride = 28'd256;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  sram_sysace_writer_if bus ();

  sram_sysace_writer #(
    .LBA_BASE  (LbaBase),
    .LBA_STRIDE(LbaStride),
    .RowBits   (RowBits)
  ) dut (
    .CLK80(clk),
    .RST  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [NWords];
  logic [20:0] addr_log [$];
  logic [15:0] hw_log [$];
  logic [15:0] exp_hw [$];
  logic [27:0] cmd_log [$];
  int          done_cnt = 0;
  bit          prev_busy = 1'b0;
  bit          bp_mode = 1'b0, hold_mode = 1'b0, hold_done = 1'b0;
  int          lat_fixed = 1, hold_cnt = 0;
  bit          rd_pend = 1'b0;
  int          rd_wait = 0;
  logic [9:0]  rd_addr = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pair p is the 48-bit value {A,B}; its three 16-bit slices go out with bytes swapped.
  task automatic build_expected();
    logic [47:0] pair;
    logic [15:0] s;
    exp_hw.delete();
    for (int p = 0; p < int'(NPairs); p++) begin
      pair = {mem[2*p][23:0], mem[2*p+1][23:0]};
      for (int k = 2; k >= 0; k--) begin
        s = pair[k*16 +: 16];
        exp_hw.push_back({s[7:0], s[15:8]});
      end
    end
  endtask

  // Environment: SRAM with one outstanding read, halfword sink and command sink, all on negedge.
  initial begin
    forever begin
      @(negedge clk);
      bus.data_r_valid = 1'b0;
      if (rd_pend) begin
        rd_wait--;
        if (rd_wait <= 0) begin
          bus.data_r_valid = 1'b1;
          bus.data_r       = mem[rd_addr];
          rd_pend          = 1'b0;
        end
      end
      bus.data_r_full = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (!rst && bus.data_r_re && !bus.data_r_full) begin
        addr_log.push_back(bus.data_r_address);
        rd_addr = bus.data_r_address[9:0];
        rd_wait = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 8));
        rd_pend = 1'b1;
      end

      bus.sysace_write_ready = bp_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (!rst && bus.sysace_write_valid && bus.sysace_write_ready) begin
        hw_log.push_back(bus.sysace_write_data);
      end

      if (hold_mode && !hold_done && bus.cmd_valid && cmd_log.size() == 1) begin
        hold_done = 1'b1;
        hold_cnt  = 20;
        check("hold_hw_count", 64'(hw_log.size()), 64'(HwPerCmd));
      end
      if (hold_cnt > 0) begin
        bus.cmd_ready = 1'b0;
        check("hold_wvalid", 64'(bus.sysace_write_valid), 64'd0);
        check("hold_cmd_lba", 64'(bus.cmd_lba), 64'(LbaStride));
        hold_cnt--;
      end else begin
        bus.cmd_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!rst && bus.cmd_valid && bus.cmd_ready) cmd_log.push_back(bus.cmd_lba);

      if (done) begin
        done_cnt++;
        check("busy_low_with_done", 64'(busy), 64'd0);
        check("busy_high_before_done", 64'(prev_busy), 64'd1);
      end
      prev_busy = busy;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
    check({tag, "_cmd_lba"}, 64'(bus.cmd_lba), 64'(LbaBase));
    check({tag, "_re"}, 64'(bus.data_r_re), 64'd0);
    check({tag, "_addr"}, 64'(bus.data_r_address), 64'd0);
    check({tag, "_wvalid"}, 64'(bus.sysace_write_valid), 64'd0);
    check({tag, "_wdata"}, 64'(bus.sysace_write_data), 64'd0);
  endtask

  // Caller is positioned just after a rising edge.
  task automatic run_frame(input string tag);
    int cyc;
    int n_bad;
    addr_log.delete();
    hw_log.delete();
    cmd_log.delete();
    done_cnt  = 0;
    hold_done = 1'b0;
    build_expected();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    repeat (6) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 40000) begin
      @(posedge clk); #2;
      cyc++;
    end
    repeat (10) @(posedge clk);
    #2;
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_re"}, 64'(bus.data_r_re), 64'd0);
    check({tag, "_hw_count"}, 64'(hw_log.size()), 64'(NHw));
    n_bad = 0;
    for (int i = 0; i < hw_log.size() && i < exp_hw.size(); i++) begin
      if (hw_log[i] !== exp_hw[i]) n_bad++;
    end
    check({tag, "_hw_mismatches"}, 64'(n_bad), 64'd0);
    check({tag, "_addr_count"}, 64'(addr_log.size()), 64'(NWords));
    n_bad = 0;
    for (int i = 0; i < addr_log.size(); i++) begin
      if (addr_log[i] !== 21'(i)) n_bad++;
    end
    check({tag, "_addr_seq_errors"}, 64'(n_bad), 64'd0);
    check({tag, "_cmd_count"}, 64'(cmd_log.size()), 64'd3);
    check({tag, "_cmd0_lba"}, 64'(cmd_log[0]), 64'd0);
    check({tag, "_cmd1_lba"}, 64'(cmd_log[1]), 64'd256);
    check({tag, "_cmd2_lba"}, 64'(cmd_log[2]), 64'd512);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    bus.cmd_ready          = 1'b1;
    bus.data_r_full        = 1'b0;
    bus.data_r             = '0;
    bus.data_r_valid       = 1'b0;
    bus.sysace_write_ready = 1'b1;
    for (int i = 0; i < int'(NWords); i++) mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check_reset_outputs("reset");
    check("reset_nsectors", 64'(bus.cmd_nsectors), 64'd0);

    // Unstalled frame, word n holds n.
    lat_fixed = 1;
    run_frame("plain");

    // Command back-pressure at the first halfword-counter wrap.
    hold_mode = 1'b1;
    run_frame("hold");
    check("hold_seen", 64'(hold_done), 64'd1);
    hold_mode = 1'b0;

    // Random data, read latency and back-pressure.
    for (int i = 0; i < int'(NWords); i++) mem[i] = $urandom;
    bp_mode   = 1'b1;
    lat_fixed = 0;
    run_frame("random");
    bp_mode = 1'b0;

    // Reset while the second read of the first pair is still outstanding.
    mem[0]    = 32'hAA112233;
    mem[1]    = 32'h55445566;
    lat_fixed = 8;
    addr_log.delete();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 0;
    while (addr_log.size() < 2 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("abort_reads_issued", 64'(addr_log.size()), 64'd2);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check_reset_outputs("abort");
    repeat (12) @(posedge clk);
    #2;
    lat_fixed = 1;
    run_frame("restart");
    check("pair_hw0", 64'(hw_log[0]), 64'h2211);
    check("pair_hw1", 64'(hw_log[1]), 64'h4433);
    check("pair_hw2", 64'(hw_log[2]), 64'h6655);
    check("restart_addr0", 64'(addr_log[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
